// File: rtl/c17_pkg.sv
// Shared definitions for the c17 block: fault-injection net indices,
// net count and the default signature polynomial.
package c17_pkg;

    // Stem index of every net in the c17 netlist, as selected by fi_net.
    typedef enum logic [3:0] {
        NET_N1  = 4'd0,
        NET_N2  = 4'd1,
        NET_N3  = 4'd2,
        NET_N6  = 4'd3,
        NET_N7  = 4'd4,
        NET_N10 = 4'd5,
        NET_N11 = 4'd6,
        NET_N16 = 4'd7,
        NET_N19 = 4'd8,
        NET_N22 = 4'd9,
        NET_N23 = 4'd10
    } c17_net_e;

    localparam int NUM_NETS = 11;

    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] C17_MISR_POLY = 16'h1021;

endpackage

// File: rtl/c17_misr.sv
// Multiple-input signature register compacting the two c17 responses.
// din[1] is folded into bit 1 and din[0] into bit 0 on every enabled edge.
module c17_misr
    import c17_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] POLY = W'(C17_MISR_POLY)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   din,
    output logic [W-1:0] sig
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;

    // Next signature: shift with polynomial feedback, then fold in the responses.
    always_comb begin
        // NOTE: the hold value is assigned first so every path drives sig_d
        // and no latch is inferred when en is low.
        sig_d = sig_q;
        if (en) begin
            sig_d = {sig_q[W-2:0], 1'b0}
                  ^ (sig_q[W-1] ? POLY : '0)
                  ^ {{(W-2){1'b0}}, din};
        end
    end

    // Signature register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so all flops update from pre-edge values.
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/c17.sv
// ISCAS c17 netlist with registered outputs, response MISR and a saturating
// pattern counter. Stem fault injection is built only when the macro
// C17_FAULT_INJECT_EN is defined; otherwise fi_* are ignored.
module c17
    import c17_pkg::*;
#(
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(C17_MISR_POLY),
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              N1,
    input  logic              N2,
    input  logic              N3,
    input  logic              N6,
    input  logic              N7,
    output logic              N22,
    output logic              N23,
    input  logic              sample_en,
    output logic              N22_q,
    output logic              N23_q,
    output logic [MISR_W-1:0] misr,
    output logic [CNT_W-1:0]  pat_cnt,
    input  logic              fi_en,
    input  logic [3:0]        fi_net,
    input  logic              fi_val
);

    // One bit per net: set when that net's stem is forced to fi_val.
    logic [NUM_NETS-1:0] fi_hit;

`ifdef C17_FAULT_INJECT_EN
    // Decode the selected net; indices past the last net force nothing.
    always_comb begin
        fi_hit = '0;
        if (fi_en && (fi_net < 4'(NUM_NETS))) begin
            fi_hit = NUM_NETS'(1) << fi_net;
        end
    end
`else
    assign fi_hit = '0;
    logic unused_fi;
    assign unused_fi = ^{fi_en, fi_net};
`endif

    // Replace a net at its stem so every fanout sees the forced value.
    function automatic logic stem(input logic hit, input logic forced, input logic raw);
        return hit ? forced : raw;
    endfunction

    logic n1, n2, n3, n6, n7, n10, n11, n16, n19, n22, n23;

    // Gate netlist; plain NAND operators keep X/Z propagation unmasked.
    always_comb begin
        n1  = stem(fi_hit[NET_N1],  fi_val, N1);
        n2  = stem(fi_hit[NET_N2],  fi_val, N2);
        n3  = stem(fi_hit[NET_N3],  fi_val, N3);
        n6  = stem(fi_hit[NET_N6],  fi_val, N6);
        n7  = stem(fi_hit[NET_N7],  fi_val, N7);
        n10 = stem(fi_hit[NET_N10], fi_val, ~(n1  & n3));
        n11 = stem(fi_hit[NET_N11], fi_val, ~(n3  & n6));
        n16 = stem(fi_hit[NET_N16], fi_val, ~(n2  & n11));
        n19 = stem(fi_hit[NET_N19], fi_val, ~(n11 & n7));
        n22 = stem(fi_hit[NET_N22], fi_val, ~(n10 & n16));
        n23 = stem(fi_hit[NET_N23], fi_val, ~(n16 & n19));
    end

    assign N22 = n22;
    assign N23 = n23;

    logic             N22_d;
    logic             N23_d;
    logic [CNT_W-1:0] pat_cnt_d;

    // Capture the responses and count patterns; the counter sticks at all-ones.
    always_comb begin
        N22_d     = N22_q;
        N23_d     = N23_q;
        pat_cnt_d = pat_cnt;
        if (sample_en) begin
            N22_d = n22;
            N23_d = n23;
            if (pat_cnt != '1) pat_cnt_d = pat_cnt + 1'b1;
        end
    end

    // Output and counter registers; reset discards everything captured so far.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            N22_q   <= 1'b0;
            N23_q   <= 1'b0;
            pat_cnt <= '0;
        end else begin
            N22_q   <= N22_d;
            N23_q   <= N23_d;
            pat_cnt <= pat_cnt_d;
        end
    end

    c17_misr #(
        .W    (MISR_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sample_en),
        .din   ({n22, n23}),
        .sig   (misr)
    );

endmodule

// File: tb/tb_c17.sv
// Scoreboard bench for c17: stimulus pushes expected responses from a
// sum-of-products / arithmetic reference model, a monitor pops and compares.
module tb_c17;

    localparam int          MW   = 16;
    localparam int          CW   = 6;
    localparam logic [15:0] POLY = 16'h1021;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clk_run = 1'b0;
    logic          rst_n;
    logic          N1, N2, N3, N6, N7;
    logic          N22, N23;
    logic          sample_en;
    logic          N22_q, N23_q;
    logic [MW-1:0] misr;
    logic [CW-1:0] pat_cnt;
    logic          fi_en;
    logic [3:0]    fi_net;
    logic          fi_val;

    c17 #(.MISR_W(MW), .MISR_POLY(POLY), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .N1(N1), .N2(N2), .N3(N3), .N6(N6), .N7(N7),
        .N22(N22), .N23(N23),
        .sample_en(sample_en),
        .N22_q(N22_q), .N23_q(N23_q),
        .misr(misr), .pat_cnt(pat_cnt),
        .fi_en(fi_en), .fi_net(fi_net), .fi_val(fi_val)
    );

    // Clock only runs once clk_run is set, so the combinational checks see no edges.
    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct {
        logic n22, n23;
        logic n22q, n23q;
        int   misr;
        int   cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference register state.
    logic m_n22q, m_n23q;
    int   m_misr, m_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // c17 outputs as sums of products, p = {N1,N2,N3,N6,N7}.
    function automatic void ref_comb(input logic [4:0] p, output logic o22, output logic o23);
        logic a, b, c, d, e;
        {a, b, c, d, e} = p;
        o22 = (a & c) | (b & !(c & d));
        o23 = !(c & d) & (b | e);
    endfunction

    function automatic void model_reset();
        m_n22q = 1'b0;
        m_n23q = 1'b0;
        m_misr = 0;
        m_cnt  = 0;
    endfunction

    // Drive one pattern now and queue what the DUT must show for it.
    task automatic apply(input logic [4:0] p, input logic se, input logic fe,
                         input logic [3:0] fn, input logic fv);
        exp_t e;
        {N1, N2, N3, N6, N7} = p;
        sample_en = se;
        fi_en = fe;
        fi_net = fn;
        fi_val = fv;
        ref_comb(p, e.n22, e.n23);
        if (se) begin
            m_n22q = e.n22;
            m_n23q = e.n23;
            m_misr = (((m_misr << 1) & 32'hFFFF) ^ (((m_misr & 32'h8000) != 0) ? int'(POLY) : 0))
                   ^ (int'(e.n22) * 2 + int'(e.n23));
            if (m_cnt < CMAX) m_cnt++;
        end
        e.n22q = m_n22q;
        e.n23q = m_n23q;
        e.misr = m_misr;
        e.cnt  = m_cnt;
        q.push_back(e);
    endtask

    task automatic issue(input logic [4:0] p, input logic se, input logic fe,
                         input logic [3:0] fn, input logic fv);
        @(posedge clk);
        #1;
        apply(p, se, fe, fn, fv);
    endtask

    // Stop sampling after the last queued edge and wait for the monitor to empty the queue.
    task automatic drain();
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        fi_en = 1'b0;
        for (int i = 0; i < 400 && q.size() != 0; i++) #1;
        check("drain", q.size(), 0);
        q.delete();
    endtask

    // Assert reset between edges and expect an immediate clear.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_misr", 32'(misr), 0);
        check("rst_cnt", 32'(pat_cnt), 0);
        check("rst_n22q", 32'(N22_q), 0);
        check("rst_n23q", 32'(N23_q), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: combinational response at the negedge, registered state after the next edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q[0];
            check("sb_n22", 32'(N22), 32'(e.n22));
            check("sb_n23", 32'(N23), 32'(e.n23));
            @(posedge clk);
            #2;
            check("sb_n22q", 32'(N22_q), 32'(e.n22q));
            check("sb_n23q", 32'(N23_q), 32'(e.n23q));
            check("sb_misr", 32'(misr), e.misr);
            check("sb_cnt", 32'(pat_cnt), e.cnt);
            void'(q.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        {N1, N2, N3, N6, N7} = 5'b00000;
        sample_en = 1'b0;
        fi_en = 1'b0;
        fi_net = 4'd0;
        fi_val = 1'b0;
        model_reset();

        // Combinational path with no clock running.
        #1;
        check("comb00000_n22", 32'(N22), 0);
        check("comb00000_n23", 32'(N23), 0);
        {N1, N2, N3, N6, N7} = 5'b11111;
        #1;
        check("comb11111_n22", 32'(N22), 1);
        check("comb11111_n23", 32'(N23), 0);
        {N1, N2, N3, N6, N7} = 5'b10101;
        #1;
        check("comb10101_n22", 32'(N22), 1);
        check("comb10101_n23", 32'(N23), 1);
        check("init_misr", 32'(misr), 0);
        check("init_cnt", 32'(pat_cnt), 0);

        clk_run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Two-pattern signature example.
        issue(5'b11111, 1'b1, 1'b0, 4'd0, 1'b0);
        issue(5'b10101, 1'b1, 1'b0, 4'd0, 1'b0);
        drain();
        check("ex_misr", 32'(misr), 32'h0007);
        check("ex_cnt", 32'(pat_cnt), 2);
        check("ex_n22q", 32'(N22_q), 1);
        check("ex_n23q", 32'(N23_q), 1);

        // Mid-operation reset, then sampling on the very first edge after release.
        do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        apply(5'b11111, 1'b1, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drain();
        check("first_edge_misr", 32'(misr), 32'h0002);

        // All 32 patterns from a clean start.
        do_reset();
        for (int p = 0; p < 32; p++) issue(5'(p), 1'b1, 1'b0, 4'd0, 1'b0);
        drain();
        check("exh_cnt", 32'(pat_cnt), 32);

        // Random patterns and enables; drives the counter into saturation.
        for (int i = 0; i < 90; i++) begin
            logic se;
            se = (i < 40) || ($urandom_range(0, 3) != 0);
`ifdef C17_FAULT_INJECT_EN
            issue(5'($urandom), se, 1'b0, 4'($urandom_range(0, 15)), 1'($urandom));
`else
            issue(5'($urandom), se, 1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
`endif
        end
        drain();
        check("sat_cnt", 32'(pat_cnt), CMAX);

        // Stem fault injection (or its absence in the default build).
        {N1, N2, N3, N6, N7} = 5'b00000;
        fi_en = 1'b1;
        fi_net = 4'd7;
        fi_val = 1'b0;
        #1;
`ifdef C17_FAULT_INJECT_EN
        check("fi_n16_n22", 32'(N22), 1);
        check("fi_n16_n23", 32'(N23), 1);
        fi_net = 4'd12;
        #1;
        check("fi_idx12_n22", 32'(N22), 0);
        check("fi_idx12_n23", 32'(N23), 0);
        {N1, N2, N3, N6, N7} = 5'b11111;
        fi_net = 4'd10;
        fi_val = 1'b1;
        #1;
        check("fi_n23_comb", 32'(N23), 1);
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        check("fi_n23_reg", 32'(N23_q), 1);
        check("fi_n23_n22q", 32'(N22_q), 1);
`else
        check("nofi_n22", 32'(N22), 0);
        check("nofi_n23", 32'(N23), 0);
`endif
        fi_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c17.md
C17 -- requirements
Module: c17

Interface
- REQ-001 Parameter: MISR_W, default 16, signature register width (minimum 4).
- REQ-002 Parameter: MISR_POLY, default 16'h1021, feedback polynomial taps (x^16+x^12+x^5+1), MISR_W bits wide.
- REQ-003 Parameter: CNT_W, default 16, pattern counter width.
- REQ-004 Port: clk  input  1  rising-edge clock.
- REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
- REQ-006 Ports: N1, N2, N3, N6, N7  input  1 each  primary inputs.
- REQ-007 Ports: N22, N23  output  1 each  combinational primary outputs.
- REQ-008 Port: sample_en  input  1  capture strobe.
- REQ-009 Ports: N22_q, N23_q  output  1 each  registered outputs.
- REQ-010 Port: misr  output  MISR_W  response signature.
- REQ-011 Port: pat_cnt  output  CNT_W  count of sampled patterns.
- REQ-012 Ports: fi_en (1), fi_net (4), fi_val (1)  input  fault-injection controls; always present.

Function
- REQ-013 Nets: N10=NAND(N1,N3), N11=NAND(N3,N6), N16=NAND(N2,N11), N19=NAND(N11,N7), N22=NAND(N10,N16), N23=NAND(N16,N19).
- REQ-014 N22/N23 shall be purely combinational, independent of clk/rst_n; they are valid within the same time step as an input change, with zero cycles of latency.
- REQ-015 On a rising clk edge with sample_en=1: N22_q<=N22, N23_q<=N23, pat_cnt<=pat_cnt+1, and misr updates.
- REQ-016 With sample_en=0, all registers shall hold.
- REQ-017 MISR update: misr <= (misr<<1) ^ (misr[MISR_W-1] ? MISR_POLY : 0) ^ {…0, N22, N23}. N22 is XORed into bit 1 and N23 into bit 0.
- REQ-018 pat_cnt shall saturate at all-ones and not wrap.
- REQ-019 X/Z on inputs shall propagate per standard NAND semantics; no masking.

Reset
- REQ-020 When rst_n=0, the block shall immediately and asynchronously force N22_q=0, N23_q=0, misr=0 and pat_cnt=0.
- REQ-021 Release of reset shall be synchronous to clk.
- REQ-022 If sample_en=1 on the first edge after release, the block shall sample on that edge.
- REQ-023 A reset asserted during operation shall discard the signature and the count.

Configuration
- REQ-024 Macro C17_FAULT_INJECT_EN defined: when fi_en=1, the net selected by fi_net shall be forced to fi_val at its stem, so that all of its fanouts see the forced value.
- REQ-025 Net index map: 0=N1, 1=N2, 2=N3, 3=N6, 4=N7, 5=N10, 6=N11, 7=N16, 8=N19, 9=N22, 10=N23; indices 11–15 shall inject no fault.
- REQ-026 A fault on N22 or N23 shall affect both the combinational output and the registered/MISR path.
- REQ-027 Macro C17_FAULT_INJECT_EN undefined: fi_en, fi_net and fi_val shall be ignored, and the logic shall be the fault-free netlist.

Structure
- REQ-028 A shared package c17_pkg shall hold the net-index enum (NET_N1 … NET_N23), NUM_NETS=11, and the default MISR_POLY constant.
- REQ-029 A single sub-module, c17_misr (parameterised by width and polynomial), shall implement the MISR.
- REQ-030 The gate netlist and fault muxing shall be coded inline in c17.

Verification
- REQ-031 Inputs N1,N2,N3,N6,N7 = 00000 -> N22=0, N23=0 after 1 ns, with no clock applied.
- REQ-032 Inputs 11111 -> N22=1, N23=0; inputs N1=1,N2=0,N3=1,N6=0,N7=1 -> N22=1, N23=1.
- REQ-033 After reset, sample 11111 and then 10101 on two edges -> misr=0x0002 after the first edge, misr=0x0007 and pat_cnt=2 after the second; N22_q=1 and N23_q=1 after the second edge.
- REQ-034 Assert rst_n=0 between edges with misr nonzero -> misr, pat_cnt, N22_q and N23_q go to 0 immediately, without waiting for a clk edge.
- REQ-035 With C17_FAULT_INJECT_EN defined, fi_en=1, fi_net=7 (N16), fi_val=0 and inputs 00000 -> N22=1, N23=1; fi_net=12 -> fault-free N22=0, N23=0.
- REQ-036 Exhaustive run of all 32 input patterns with sample_en=1 -> every combinational output matches the REQ-013 equations, and pat_cnt=32.
